i2s_tx_serializer: RTL and testbench



---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_tx_serializer_edge.sv | 30 +++
 rtl/i2s_tx_serializer.sv | 182 ++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Purpose     : shared I2S transmit constants and types for the serializer slice.
// Latency     : n/a (types and constants only).
// Backpressure: n/a.
// Contents    : default sample/slot widths, packed stereo frame, channel encoding of WS.
package i2s_pkg;

    // Default sample width and bit-clock periods per WS half.
    localparam int I2S_SAMPLE_WIDTH = 24;
    localparam int I2S_SLOT_WIDTH   = 24;

    // One stereo PCM frame, two's complement per channel.
    typedef struct packed {
        logic [I2S_SAMPLE_WIDTH-1:0] left;
        logic [I2S_SAMPLE_WIDTH-1:0] right;
    } i2s_frame_t;

    // Word-select level meaning: 0 selects the left slot, 1 the right slot.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

endpackage

// File: rtl/i2s_tx_serializer_edge.sv
// Purpose     : registers one synchronous level and reports its rising/falling edges.
// Latency     : edges are combinational against a 1-cycle delayed copy; o_dly is 1 cycle late.
// Backpressure: none.
// Ports       : clk_ref/rst (sync, active-high); i_level in; o_rise, o_fall, o_dly out.
module i2s_edge_detect
    import i2s_pkg::*;
(
    input  logic clk_ref,
    input  logic rst,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_dly
);

    logic r_q;

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_level;
        end
    end

    assign o_rise = ~r_q &  i_level;
    assign o_fall =  r_q & ~i_level;
    assign o_dly  =  r_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Purpose     : I2S transmit serializer; stereo frames in over valid/ready, MSB-first serial data out.
// Latency     : first MSB on i2s_sd one bclk period after the WS 1->0 edge that loads the frame.
// Backpressure: one-frame holding buffer; frame_ready drops while full until the next left-slot load.
// Ports       : clk_ref/rst (sync, active-high); clk_bit/clk_ws levels from the I2S clock generator;
//               frame_valid/frame_ready/frame_left/frame_right upstream handshake;
//               i2s_bclk/i2s_ws/i2s_sd pins; underrun/align_err pulses; underrun_count saturating.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    // SAMPLE_WIDTH must not exceed SLOT_WIDTH; SLOT_WIDTH must match the generator's bits per WS half.
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
    input  logic                    clk_ref,
    input  logic                    rst,
    input  logic                    clk_bit,
    input  logic                    clk_ws,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [SAMPLE_WIDTH-1:0] frame_left,
    input  logic [SAMPLE_WIDTH-1:0] frame_right,
    output logic                    i2s_bclk,
    output logic                    i2s_ws,
    output logic                    i2s_sd,
    output logic                    underrun,
    output logic                    align_err,
    output logic [15:0]             underrun_count
);

    localparam int              PAD      = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam int              CNT_W    = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_WIDTH - 1);

    // ------------------------------------------------------------------
    // Edge detection on the generator levels
    // ------------------------------------------------------------------
    logic w_bclk_rise_unused;
    logic w_bclk_fall;
    logic w_bclk_q;
    logic w_ws_rise;
    logic w_ws_fall;
    logic w_ws_q;

    i2s_edge_detect u_bclk_edge (
        .clk_ref (clk_ref),
        .rst     (rst),
        .i_level (clk_bit),
        .o_rise  (w_bclk_rise_unused),
        .o_fall  (w_bclk_fall),
        .o_dly   (w_bclk_q)
    );

    i2s_edge_detect u_ws_edge (
        .clk_ref (clk_ref),
        .rst     (rst),
        .i_level (clk_ws),
        .o_rise  (w_ws_rise),
        .o_fall  (w_ws_fall),
        .o_dly   (w_ws_q)
    );

    // The generator only moves WS together with a bclk fall, so a WS change
    // is qualified by the fall to ignore anything that is not a real slot boundary.
    logic w_ws_edge;
    logic w_left_edge;
    logic w_right_edge;

    assign w_ws_edge    = w_bclk_fall & (w_ws_rise | w_ws_fall);
    assign w_left_edge  = w_ws_edge & (i2s_chan_e'(clk_ws) == LEFT);
    assign w_right_edge = w_ws_edge & (i2s_chan_e'(clk_ws) == RIGHT);

    // ------------------------------------------------------------------
    // One-frame holding buffer
    // ------------------------------------------------------------------
    logic [SAMPLE_WIDTH-1:0] r_buf_left;
    logic [SAMPLE_WIDTH-1:0] r_buf_right;
    logic                    r_buf_valid;
    logic                    w_consume;
    logic                    w_accept;

    // Ready is granted in the consuming cycle too, so a continuously valid
    // source refills the buffer on the same edge it is drained.
    assign w_consume   = w_left_edge & r_buf_valid;
    assign frame_ready = ~r_buf_valid | w_consume;
    assign w_accept    = frame_valid & frame_ready;

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_buf_left  <= '0;
            r_buf_right <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf_left  <= frame_left;
                r_buf_right <= frame_right;
                r_buf_valid <= 1'b1;
            end else if (w_consume) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    // Samples are left-justified in the slot; unused LSBs go out as zeros.
    logic [SLOT_WIDTH-1:0] w_left_slot;
    logic [SLOT_WIDTH-1:0] w_right_slot;

    assign w_left_slot  = SLOT_WIDTH'(r_buf_left)  << PAD;
    assign w_right_slot = SLOT_WIDTH'(r_buf_right) << PAD;

    // ------------------------------------------------------------------
    // Shifter, bit counter and status
    // ------------------------------------------------------------------
    logic [SLOT_WIDTH-1:0] r_sh;
    logic [SLOT_WIDTH-1:0] r_right_hold;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_armed;
    logic                  r_sd;
    logic                  r_underrun;
    logic                  r_align_err;
    logic [15:0]           r_underrun_count;

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_sh             <= '0;
            r_right_hold     <= '0;
            r_bit_cnt        <= '0;
            r_armed          <= 1'b0;
            r_sd             <= 1'b0;
            r_underrun       <= 1'b0;
            r_align_err      <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_underrun  <= 1'b0;
            r_align_err <= 1'b0;

            // Every bclk fall drives the next pending bit. On a WS edge that bit
            // is the previous word's LSB, which produces the one-bit I2S delay.
            if (w_bclk_fall) begin
                r_sd <= r_sh[SLOT_WIDTH-1];
            end

            if (w_left_edge) begin
                if (r_buf_valid) begin
                    r_sh         <= w_left_slot;
                    r_right_hold <= w_right_slot;
                end else begin
                    r_sh         <= '0;
                    r_right_hold <= '0;
                    r_underrun   <= 1'b1;
                    if (r_underrun_count != 16'hFFFF) begin
                        r_underrun_count <= r_underrun_count + 16'd1;
                    end
                end
            end else if (w_right_edge) begin
                r_sh <= r_right_hold;
            end else if (w_bclk_fall) begin
                r_sh <= r_sh << 1;
                if (r_bit_cnt != CNT_LAST) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end

            // A well-formed half slot has SLOT_WIDTH-1 plain falls between WS edges.
            // The first edge after reset follows an arbitrary partial slot, so it only arms.
            if (w_ws_edge) begin
                if (r_armed && (r_bit_cnt != CNT_LAST)) begin
                    r_align_err <= 1'b1;
                end
                r_bit_cnt <= '0;
                r_armed   <= 1'b1;
            end
        end
    end

    assign i2s_bclk       = w_bclk_q;
    assign i2s_ws         = w_ws_q;
    assign i2s_sd         = r_sd;
    assign underrun       = r_underrun;
    assign align_err      = r_align_err;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Purpose     : directed bench for i2s_tx_serializer (24-bit and 16-in-24 slot instances).
// Latency     : n/a.
// Backpressure: frames are driven with valid held until frame_ready.
module tb_i2s_tx_serializer;
    import i2s_pkg::*;

    localparam int BCLK_NCYCLES = 2;

    logic clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    logic        rst         = 1'b1;
    logic        clk_bit     = 1'b0;
    logic        clk_ws      = 1'b0;
    logic        frame_valid = 1'b0;
    logic [23:0] frame_left  = '0;
    logic [23:0] frame_right = '0;
    logic [15:0] left16      = '0;
    logic [15:0] right16     = '0;

    logic        dut_frame_ready, dut_bclk, dut_ws, dut_sd, dut_underrun, dut_align_err;
    logic [15:0] dut_ur_count;
    logic        d16_frame_ready, d16_bclk, d16_ws, d16_sd, d16_underrun, d16_align_err;
    logic [15:0] d16_ur_count;

    i2s_tx_serializer #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(24)) u_dut (
        .clk_ref(clk_ref), .rst(rst), .clk_bit(clk_bit), .clk_ws(clk_ws),
        .frame_valid(frame_valid), .frame_ready(dut_frame_ready),
        .frame_left(frame_left), .frame_right(frame_right),
        .i2s_bclk(dut_bclk), .i2s_ws(dut_ws), .i2s_sd(dut_sd),
        .underrun(dut_underrun), .align_err(dut_align_err), .underrun_count(dut_ur_count)
    );

    i2s_tx_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(24)) u_dut16 (
        .clk_ref(clk_ref), .rst(rst), .clk_bit(clk_bit), .clk_ws(clk_ws),
        .frame_valid(frame_valid), .frame_ready(d16_frame_ready),
        .frame_left(left16), .frame_right(right16),
        .i2s_bclk(d16_bclk), .i2s_ws(d16_ws), .i2s_sd(d16_sd),
        .underrun(d16_underrun), .align_err(d16_align_err), .underrun_count(d16_ur_count)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Clock generator state (I2S_BCLK_NCYCLES=2, bits per WS half in ws_nbits).
    bit gen_run  = 1'b0;
    int gen_div  = 0;
    int gen_bits = 0;
    int ws_nbits = 24;

    bit prev_bclk = 1'b0, prev_ws = 1'b0;
    bit bclk_rose, ws_fell, ws_tog;
    int ur_seen = 0, ae_seen = 0, ae16_seen = 0, sd_ones = 0, hs_seen = 0;
    bit cap_on = 1'b0;
    bit q24[$];
    bit q16[$];
    bit stream_on = 1'b0;
    int stream_idx = 0;

    i2s_frame_t stream_tab [8] = '{
        '{24'h123456, 24'h654321}, '{24'h800000, 24'h000000},
        '{24'h7FFFFF, 24'h800001}, '{24'h000001, 24'hFFFFFE},
        '{24'hFFFFFF, 24'h13579B}, '{24'h5A5A5A, 24'h2468AC},
        '{24'hA5A5A5, 24'hC0FFEE}, '{24'h0F0F0F, 24'h00FF00}
    };

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        chk_cnt++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // One clk_ref cycle: sample outputs 1 time unit after the edge, then advance the generator.
    task automatic tick();
        logic hs;
        #1;
        hs = frame_valid & dut_frame_ready;
        @(posedge clk_ref);
        #1;
        bclk_rose = !prev_bclk && dut_bclk;
        ws_fell   = prev_ws && !dut_ws;
        ws_tog    = prev_ws != dut_ws;
        prev_bclk = dut_bclk;
        prev_ws   = dut_ws;
        if (dut_underrun)  ur_seen++;
        if (dut_align_err) ae_seen++;
        if (d16_align_err) ae16_seen++;
        if (dut_sd)        sd_ones++;
        if (hs) begin
            hs_seen++;
            if (stream_on) begin
                stream_idx++;
                if (stream_idx < 8) begin
                    frame_left  = stream_tab[stream_idx].left;
                    frame_right = stream_tab[stream_idx].right;
                end else begin
                    frame_valid = 1'b0;
                end
            end
        end
        if (cap_on && bclk_rose) begin
            q24.push_back(dut_sd);
            q16.push_back(d16_sd);
        end
        if (gen_run) begin
            gen_div++;
            if (gen_div == BCLK_NCYCLES) begin
                gen_div = 0;
                if (clk_bit) begin
                    clk_bit = 1'b0;
                    gen_bits++;
                    if (gen_bits >= ws_nbits) begin
                        gen_bits = 0;
                        clk_ws   = ~clk_ws;
                    end
                end else begin
                    clk_bit = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_ws_fall();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ws_fell && n < 500);
        if (!ws_fell) timeout_fail("wait_ws_fall");
    endtask

    task automatic wait_ws_toggles(input int count);
        int seen = 0;
        int n    = 0;
        while (seen < count && n < 1000) begin
            tick();
            n++;
            if (ws_tog) seen++;
        end
        if (seen < count) timeout_fail("wait_ws_toggles");
    endtask

    // Collect n i2s_sd samples on i2s_bclk rising edges.
    task automatic capture(input int n);
        int guard = 0;
        q24.delete();
        q16.delete();
        cap_on = 1'b1;
        while (q24.size() < n && guard < n * 8 + 16) begin
            tick();
            guard++;
        end
        cap_on = 1'b0;
        if (q24.size() < n) timeout_fail("capture");
    endtask

    // 24 MSB-first samples starting at index base; missing samples read as X.
    function automatic logic [23:0] get_word(input bit use16, input int base);
        logic [23:0] w = '0;
        for (int j = 0; j < 24; j++) begin
            int  idx;
            logic b;
            idx = base + j;
            if (use16) b = (idx < q16.size()) ? q16[idx] : 1'bx;
            else       b = (idx < q24.size()) ? q24[idx] : 1'bx;
            w = {w[22:0], b};
        end
        return w;
    endfunction

    task automatic check_reset_state(input string pfx);
        check({pfx, "_bclk"},  48'(dut_bclk),        48'd0);
        check({pfx, "_ws"},    48'(dut_ws),          48'd0);
        check({pfx, "_sd"},    48'(dut_sd),          48'd0);
        check({pfx, "_ur"},    48'(dut_underrun),    48'd0);
        check({pfx, "_ae"},    48'(dut_align_err),   48'd0);
        check({pfx, "_urcnt"}, 48'(dut_ur_count),    48'd0);
        check({pfx, "_ready"}, 48'(dut_frame_ready), 48'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");

        // No frames for three WS periods: silent output, one underrun per left load
        rst     = 1'b0;
        gen_run = 1'b1;
        ur_seen = 0; ae_seen = 0; sd_ones = 0;
        repeat (3) wait_ws_fall();
        check("idle_ur_pulses", 48'(ur_seen),      48'd3);
        check("idle_ur_count",  48'(dut_ur_count), 48'd3);
        check("idle_sd_zero",   48'(sd_ones),      48'd0);
        check("idle_align",     48'(ae_seen),      48'd0);

        // Constant frames, and 16-bit samples left-justified in a 24-bit slot
        frame_left  = 24'h800001;
        frame_right = 24'h7FFFFE;
        left16      = 16'hABCD;
        right16     = 16'h1234;
        frame_valid = 1'b1;
        ur_seen = 0; ae_seen = 0;
        wait_ws_fall();
        capture(49);
        check("const_left",    48'(get_word(1'b0, 1)),  48'h800001);
        check("const_right",   48'(get_word(1'b0, 25)), 48'h7FFFFE);
        check("w16_left",      48'(get_word(1'b1, 1)),  48'hABCD00);
        check("w16_right",     48'(get_word(1'b1, 25)), 48'h123400);
        check("const_ur",      48'(ur_seen),            48'd0);
        check("const_align",   48'(ae_seen),            48'd0);

        // Drain the buffer, then stream 8 distinct frames with valid held high
        frame_valid = 1'b0;
        wait_ws_fall();
        ur_seen = 0; ae_seen = 0; hs_seen = 0;
        stream_idx  = 0;
        frame_left  = stream_tab[0].left;
        frame_right = stream_tab[0].right;
        stream_on   = 1'b1;
        frame_valid = 1'b1;
        wait_ws_fall();
        capture(1 + 48 * 8);
        stream_on = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stream_l%0d", k), 48'(get_word(1'b0, 1 + 48 * k)),  48'(stream_tab[k].left));
            check($sformatf("stream_r%0d", k), 48'(get_word(1'b0, 25 + 48 * k)), 48'(stream_tab[k].right));
        end
        check("stream_handshakes", 48'(hs_seen),      48'd8);
        check("stream_ur_pulses",  48'(ur_seen),      48'd1);
        check("stream_ur_count",   48'(dut_ur_count), 48'd4);
        check("stream_align",      48'(ae_seen),      48'd0);

        // One-cycle reset in the middle of a left slot carrying all ones
        frame_left  = 24'hFFFFFF;
        frame_right = 24'hFFFFFF;
        frame_valid = 1'b1;
        wait_ws_fall();
        frame_valid = 1'b0;
        repeat (20) tick();
        check("pre_rst_sd", 48'(dut_sd), 48'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        sd_ones = 0; ae_seen = 0; ur_seen = 0;
        frame_left  = 24'h5A5A5A;
        frame_right = 24'h3C3C3C;
        frame_valid = 1'b1;
        wait_ws_fall();
        check("post_rst_quiet", 48'(sd_ones), 48'd0);
        capture(49);
        frame_valid = 1'b0;
        check("post_rst_left",  48'(get_word(1'b0, 1)),  48'h5A5A5A);
        check("post_rst_right", 48'(get_word(1'b0, 25)), 48'h3C3C3C);
        check("post_rst_align", 48'(ae_seen),            48'd0);
        check("post_rst_ur",    48'(ur_seen),            48'd0);

        // Generator with 23 bits per WS half: every WS edge is misaligned
        wait_ws_fall();
        ws_nbits  = 23;
        ae_seen   = 0;
        ae16_seen = 0;
        wait_ws_toggles(4);
        check("align23_err",   48'(ae_seen),   48'd4);
        check("align23_err16", 48'(ae16_seen), 48'd4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
